// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the RISC-V unified memory responder.
package riscv_mem_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned StrbW = 4;
  localparam logic [WordW-1:0] RdataRst = '0;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_state_e;

  // Full addr[31:2] is range-checked so out-of-range addresses never alias into the array.
  function automatic logic addr_fault(input logic [WordW-1:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[WordW-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Core-to-memory request/response bus.
interface riscv_mem_responder_if;
  import riscv_mem_pkg::*;

  logic             req;
  logic             we;
  logic [WordW-1:0] addr;
  logic [WordW-1:0] wdata;
  logic [StrbW-1:0] wstrb;
  logic [WordW-1:0] rdata;
  logic             ready;
  logic             err;

  modport master (output req, we, addr, wdata, wstrb, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, wstrb, output rdata, ready, err);

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM with per-byte write enables and registered read data.
module mem_array
  import riscv_mem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IdxW        = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [StrbW-1:0] be,
  input  logic [IdxW-1:0]  idx,
  input  logic [WordW-1:0] wdata,
  output logic [WordW-1:0] rdata
);

  logic [WordW-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(StrbW); i++) begin
      if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/riscv_mem_responder.sv
// Unified I/D memory: one request at a time, fixed wait states, one-cycle ready pulse.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  riscv_mem_responder_if.slave  bus
);

  localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  mem_state_e       state_q;
  logic [3:0]       cnt_q;
  logic             ready_q, err_q, rd_en_q;
  logic [IdxW-1:0]  idx_q;
  logic             we_q, fault_q;
  logic [WordW-1:0] wdata_q;
  logic [StrbW-1:0] wstrb_q;

  logic             req_fault;
  logic [IdxW-1:0]  ram_idx;
  logic [StrbW-1:0] ram_be;
  logic [WordW-1:0] ram_rdata;

  assign req_fault = addr_fault(bus.addr, DEPTH_WORDS);

  // In IDLE the live address feeds the RAM so a zero-wait read lands on the accepting edge.
  assign ram_idx = (state_q == MEM_IDLE) ? bus.addr[IdxW+1:2] : idx_q;
  assign ram_be  = (state_q == MEM_RESP && we_q && !fault_q && !reset) ? wstrb_q : '0;

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem_array (
    .clk   (clk),
    .be    (ram_be),
    .idx   (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rd_en_q <= 1'b0;
      unique case (state_q)
        MEM_IDLE: begin
          if (bus.req) begin
            idx_q   <= bus.addr[IdxW+1:2];
            we_q    <= bus.we;
            wdata_q <= bus.wdata;
            wstrb_q <= bus.wstrb;
            fault_q <= req_fault;
            if (WAIT_CYCLES == 0) begin
              state_q <= MEM_RESP;
              ready_q <= 1'b1;
              err_q   <= req_fault;
              rd_en_q <= !bus.we && !req_fault;
            end else begin
              state_q <= MEM_WAIT;
              cnt_q   <= CntInit;
            end
          end
        end
        MEM_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= MEM_RESP;
            ready_q <= 1'b1;
            err_q   <= fault_q;
            rd_en_q <= !we_q && !fault_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        MEM_RESP: state_q <= MEM_IDLE;
        default:  state_q <= MEM_IDLE;
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rd_en_q ? ram_rdata : RdataRst;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench: table-driven transactions plus scoreboarded responses on two configurations.
module tb_riscv_mem_responder;
  import riscv_mem_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q2[$];
  exp_t q0[$];

  always #5 clk = ~clk;

  riscv_mem_responder_if bus2 ();
  riscv_mem_responder_if bus0 ();

  riscv_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  riscv_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop one expectation per ready pulse; outputs must be quiet otherwise.
  task automatic mon(input bit sel, input logic rdy, input logic [31:0] rd, input logic er);
    exp_t e;
    if (rdy) begin
      if ((sel ? q0.size() : q2.size()) == 0) begin
        check(sel ? "dut0_unexpected_ready" : "dut2_unexpected_ready", {31'b0, rdy}, 32'd0);
      end else begin
        e = sel ? q0.pop_front() : q2.pop_front();
        check(sel ? "dut0_rdata" : "dut2_rdata", rd, e.rdata);
        check(sel ? "dut0_err" : "dut2_err", {31'b0, er}, {31'b0, e.err});
      end
    end else begin
      check(sel ? "dut0_idle_rdata" : "dut2_idle_rdata", rd, 32'd0);
      check(sel ? "dut0_idle_err" : "dut2_idle_err", {31'b0, er}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      mon(1'b0, bus2.ready, bus2.rdata, bus2.err);
      mon(1'b1, bus0.ready, bus0.rdata, bus0.err);
    end
  end

  task automatic set_bus(input bit sel, input logic rq, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    if (sel) begin
      bus0.req = rq; bus0.we = w; bus0.addr = a; bus0.wdata = d; bus0.wstrb = s;
    end else begin
      bus2.req = rq; bus2.we = w; bus2.addr = a; bus2.wdata = d; bus2.wstrb = s;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus0.ready : bus2.ready;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] rd, input logic er);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    return e;
  endfunction

  // Entered just after a rising edge with the DUT idle; returns likewise.
  task automatic xact(input bit sel, input vec_t v);
    int lat;
    set_bus(sel, 1'b1, v.we, v.addr, v.wdata, v.wstrb);
    if (sel) q0.push_back(mk_exp(v.exp_rdata, v.exp_err));
    else     q2.push_back(mk_exp(v.exp_rdata, v.exp_err));
    @(posedge clk); #1;
    set_bus(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rdy(sel) && lat < 20);
    check(sel ? "dut0_latency" : "dut2_latency", lat, sel ? 32'd1 : 32'd3);
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.wstrb = s; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  vec_t tbl[$];
  int   lat;
  logic [5:0] pulses;
  logic [31:0] seq_addr [6];

  initial begin
    tbl.push_back(mk(1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 0));
    tbl.push_back(mk(0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 0));
    tbl.push_back(mk(1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 0));
    tbl.push_back(mk(0, 32'h20, 32'h0, 4'b0000, 32'h11BB33DD, 0));
    tbl.push_back(mk(1, 32'h0, 32'hCAFEF00D, 4'b1111, 32'h0, 0));
    tbl.push_back(mk(0, 32'h13, 32'h0, 4'b0000, 32'h0, 1));
    tbl.push_back(mk(1, 32'h100, 32'hFFFFFFFF, 4'b1111, 32'h0, 1));
    tbl.push_back(mk(0, 32'h0, 32'h0, 4'b0000, 32'hCAFEF00D, 0));
    tbl.push_back(mk(0, 32'h80000000, 32'h0, 4'b0000, 32'h0, 1));
    tbl.push_back(mk(1, 32'h24, 32'h01020304, 4'b1111, 32'h0, 0));
    tbl.push_back(mk(1, 32'h24, 32'hFFFFFFFF, 4'b0000, 32'h0, 0));
    tbl.push_back(mk(0, 32'h24, 32'h0, 4'b0000, 32'h01020304, 0));
    tbl.push_back(mk(1, 32'hFC, 32'h600DD00D, 4'b1111, 32'h0, 0));
    tbl.push_back(mk(0, 32'hFC, 32'h0, 4'b0000, 32'h600DD00D, 0));
    tbl.push_back(mk(1, 32'h8, 32'h0BADCAFE, 4'b1111, 32'h0, 0));

    reset = 1'b1;
    set_bus(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_bus(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'b0, bus2.ready}, 32'd0);
    check("reset_err", {31'b0, bus2.err}, 32'd0);
    check("reset_rdata", bus2.rdata, 32'd0);
    @(posedge clk); #1;

    foreach (tbl[i]) xact(0, tbl[i]);

    // Reset lands in the RESP cycle of a store: the write must be dropped.
    set_bus(0, 1'b1, 1'b1, 32'h8, 32'h12345678, 4'b1111);
    @(posedge clk); #1;
    set_bus(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_ready", {31'b0, bus2.ready}, 32'd0);
    check("midreset_err", {31'b0, bus2.err}, 32'd0);
    check("midreset_rdata", bus2.rdata, 32'd0);
    @(posedge clk); #1;
    xact(0, mk(0, 32'h8, 32'h0, 4'b0000, 32'h0BADCAFE, 0));

    // Request pulsed during WAIT must be ignored.
    set_bus(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
    q2.push_back(mk_exp(32'hDEADBEEF, 1'b0));
    @(posedge clk); #1;
    set_bus(0, 1'b1, 1'b0, 32'h40, 32'd0, 4'd0);
    @(posedge clk); #1;
    set_bus(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus2.ready && lat < 20);
    check("wait_req_latency", lat, 32'd2);
    repeat (8) begin
      @(negedge clk);
      check("wait_req_ignored", {31'b0, bus2.ready}, 32'd0);
    end
    @(posedge clk); #1;

    // Zero-wait configuration: req held high, responses every second cycle, RESP never accepts.
    xact(1, mk(1, 32'h0, 32'hA1A1A1A1, 4'b1111, 32'h0, 0));
    xact(1, mk(1, 32'h4, 32'hB2B2B2B2, 4'b1111, 32'h0, 0));
    xact(1, mk(1, 32'h8, 32'hC3C3C3C3, 4'b1111, 32'h0, 0));
    seq_addr[0] = 32'h0; seq_addr[1] = 32'h8; seq_addr[2] = 32'h4;
    seq_addr[3] = 32'h8; seq_addr[4] = 32'h0; seq_addr[5] = 32'h8;
    q0.push_back(mk_exp(32'hA1A1A1A1, 1'b0));
    q0.push_back(mk_exp(32'hB2B2B2B2, 1'b0));
    q0.push_back(mk_exp(32'hA1A1A1A1, 1'b0));
    for (int k = 0; k < 6; k++) begin
      set_bus(1, 1'b1, 1'b0, seq_addr[k], 32'd0, 4'd0);
      @(negedge clk);
      pulses[k] = bus0.ready;
      @(posedge clk); #1;
    end
    set_bus(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check("b2b_pulse_pattern", {26'b0, pulses}, 32'b101010);
    repeat (4) begin
      @(negedge clk);
      check("b2b_no_extra_ready", {31'b0, bus0.ready}, 32'd0);
    end
    @(posedge clk); #1;

    check("dut2_queue_drained", q2.size(), 32'd0);
    check("dut0_queue_drained", q0.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_mem_responder.md
# riscv_mem_responder

Unified instruction/data memory that sits on the far side of the multi-cycle RISC-V core's memory port and answers its fetch, load and store requests. It accepts one word-aligned request at a time, inserts a fixed, parameterised number of wait states, then returns read data or commits byte-masked write data with a one-cycle `ready` pulse. Misaligned or out-of-range addresses complete with `err` instead of touching the array.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; must be a power of two ≥ 4.
- `WAIT_CYCLES`, 2: wait states between acceptance and response, 0–15.

Ports:
- `clk`  in  1: the single clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  1: request valid; sampled only in IDLE.
- `we`  in  1: 1 = store, 0 = load or fetch.
- `addr`  in  32: byte address.
- `wdata`  in  32: store data.
- `wstrb`  in  4: byte enables; bit i writes `wdata[8i+7:8i]`.
- `rdata`  out  32: read word; valid only while `ready` = 1.
- `ready`  out  1: one-cycle completion pulse.
- `err`  out  1: asserted together with `ready` when the access faulted.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - On `req` = 1: latch `addr`, `we`, `wdata`, `wstrb`.
  - Go to WAIT with `cnt` = `WAIT_CYCLES` − 1, or directly to RESP if `WAIT_CYCLES` = 0.
  - On `req` = 0: stay in IDLE.
- **WAIT**
  - Decrement `cnt` each cycle.
  - When `cnt` = 0, go to RESP.
  - `req` is ignored in this state.
- **RESP**
  - Drive `ready` = 1 for exactly one cycle, then return to IDLE.
  - A new request can be accepted in the IDLE cycle that follows. RESP never accepts a request.
- **Fault check** (evaluated on the latched address)
  - Fault if `addr[1:0]` ≠ 0, or if `addr[31:2]` ≥ `DEPTH_WORDS`.
  - On fault: `err` = 1 in RESP, `rdata` = 0, no array write.
- **Read** (`we` = 0)
  - The array is read during the last cycle before RESP.
  - `rdata` presents the full 32-bit word for the RESP cycle only. It is 0 in every other cycle.
- **Write** (`we` = 1)
  - Commit at the clock edge that ends the RESP cycle, only for bytes whose `wstrb` bit is 1.
  - `wstrb` = 0000 completes normally with no array change.
  - `rdata` = 0 during a write response.
- **Index width:** the word index is `addr[$clog2(DEPTH_WORDS)+1:2]`. The range check uses the full `addr[31:2]` to prevent aliasing.
- **Reset values:** `ready` = 0, `err` = 0, `rdata` = 0, state = IDLE, `cnt` = 0.
- **Reset mid-operation:** abandon the transaction. A pending write is dropped, even if `reset` coincides with the RESP cycle.
- **Contents across reset:** array contents are not cleared by reset.
- **Simultaneous `req` and `reset`:** reset wins and the request is not accepted.

## Timing
- Request accepted at edge N (`req` high in IDLE) → `ready` high in cycle N + 1 + `WAIT_CYCLES`.
- `WAIT_CYCLES` = 0 gives `ready` in the cycle after acceptance.
- Maximum throughput: one access per `WAIT_CYCLES` + 2 cycles.
- Store data becomes visible to a load accepted in the IDLE cycle immediately after the store's RESP.
- The array is synchronous read and write, single port, with no combinational path from inputs to outputs.

## Structure
- **Package `riscv_mem_pkg`:**
  - state enum (`MEM_IDLE`, `MEM_WAIT`, `MEM_RESP`);
  - word width 32;
  - strobe width 4;
  - reset value of `rdata`.
- **Sub-module `mem_array`:**
  - single-port synchronous RAM, parameterised by `DEPTH_WORDS`;
  - ports: per-byte write enables, `clk`, word index, write data, read data.
- **`riscv_mem_responder` itself** holds the FSM, the wait counter, the request latches and the fault check.

## Test plan
1. **Store then load.** `WAIT_CYCLES` = 2.
   - Store `addr` = 0x10, `wdata` = 0xDEADBEEF, `wstrb` = 1111 → `ready` 3 cycles after acceptance, `err` = 0.
   - Then load 0x10 → `rdata` = 0xDEADBEEF with `ready`.
2. **Byte-masked store.**
   - Preload 0x20 with 0x11223344.
   - Store 0xAABBCCDD with `wstrb` = 0101 → a later load returns 0x11BB33DD.
3. **Faults.**
   - Load `addr` = 0x13 → `ready` = 1, `err` = 1, `rdata` = 0.
   - Store `addr` = `DEPTH_WORDS`×4 → `err` = 1, and word 0 is unchanged (no aliasing).
4. **`WAIT_CYCLES` = 0 back-to-back.**
   - Hold `req` high for 6 cycles with loads to 0x0 and 0x4 → `ready` pulses every 2nd cycle.
   - `req` during RESP is not accepted.
5. **Reset mid-write.**
   - Assert `reset` in the RESP cycle of a store of 0x12345678 to 0x8 → no `ready`.
   - A later load of 0x8 returns the old value.
   - `ready`, `err` and `rdata` are 0 after reset.
6. **Ignored request during WAIT.**
   - Pulse `req` with `addr` = 0x40 while in WAIT → only the original transaction completes.
   - The FSM returns to IDLE, and the 0x40 access never responds.
